// File: rtl/rv32i_lsu.sv
// RV32I load/store unit: one access at a time over a word-addressed data bus with
// byte enables, returning sign/zero-extended load data to register writeback.

package rv32i;

  typedef enum logic {
    MEM_LOAD  = 1'b0,
    MEM_STORE = 1'b1
  } mem_op_e;

  typedef enum logic [1:0] {
    RAM_B = 2'd0,
    RAM_H = 2'd1,
    RAM_W = 2'd2
  } ram_mask_e;

  typedef enum logic [2:0] {
    REG_B  = 3'd0,
    REG_H  = 3'd1,
    REG_W  = 3'd2,
    REG_BX = 3'd3,
    REG_HX = 3'd4
  } reg_mask_e;

endpackage

module rv32i_lsu
  import rv32i::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              reset_n,

  input  logic              in_valid,
  output logic              in_ready,
  input  mem_op_e           in_mem_op,
  input  ram_mask_e         in_ram_mask,
  input  reg_mask_e         in_reg_mask,
  input  logic [ADDR_W-1:0] in_addr,
  input  logic [31:0]       in_wdata,
  input  logic [4:0]        in_rd,

  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [3:0]        mem_be,
  output logic [31:0]       mem_wdata,
  input  logic              mem_gnt,
  input  logic              mem_rvalid,
  input  logic [31:0]       mem_rdata,

  output logic              done_valid,
  output logic              done_err,
  output logic              done_we,
  output logic [4:0]        done_rd,
  output logic [31:0]       done_data
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_RESP
  } state_e;

  typedef enum logic [1:0] {
    W_BYTE,
    W_HALF,
    W_WORD,
    W_BAD
  } width_e;

  state_e            state_q;
  state_e            state_d;

  logic              is_store_q;
  reg_mask_e         reg_mask_q;
  logic [1:0]        off_q;
  logic [ADDR_W-1:2] addr_q;
  logic [3:0]        be_q;
  logic [31:0]       wdata_q;
  logic [31:0]       data_q;
  logic [4:0]        rd_q;
  logic              err_q;

  width_e            acc_width;
  logic              acc_misaligned;
  logic              acc_ok;
  logic [3:0]        acc_be;
  logic [31:0]       acc_wdata;
  logic              accept;

  assign accept = in_valid && (state_q == S_IDLE);

  // Loads take their width from reg_mask, stores from ram_mask; unused encodings are illegal.
  always_comb begin
    acc_width = W_BAD;
    if (in_mem_op == MEM_STORE) begin
      case (in_ram_mask)
        RAM_B:   acc_width = W_BYTE;
        RAM_H:   acc_width = W_HALF;
        RAM_W:   acc_width = W_WORD;
        default: acc_width = W_BAD;
      endcase
    end else begin
      case (in_reg_mask)
        REG_B, REG_BX: acc_width = W_BYTE;
        REG_H, REG_HX: acc_width = W_HALF;
        REG_W:         acc_width = W_WORD;
        default:       acc_width = W_BAD;
      endcase
    end
  end

  always_comb begin
    acc_misaligned = 1'b0;
    acc_be         = 4'b0000;
    acc_wdata      = in_wdata;
    case (acc_width)
      W_BYTE: begin
        acc_be    = 4'b0001 << in_addr[1:0];
        acc_wdata = {4{in_wdata[7:0]}};
      end
      W_HALF: begin
        acc_misaligned = in_addr[0];
        acc_be         = 4'b0011 << {in_addr[1], 1'b0};
        acc_wdata      = {2{in_wdata[15:0]}};
      end
      W_WORD: begin
        acc_misaligned = |in_addr[1:0];
        acc_be         = 4'b1111;
      end
      default: ;
    endcase
    acc_ok = (acc_width != W_BAD) && !acc_misaligned;
  end

  function automatic logic [31:0] extract_load(input logic [31:0] word,
                                               input reg_mask_e   mask,
                                               input logic [1:0]  off);
    logic [31:0] lane;
    lane = word >> {off, 3'b000};
    case (mask)
      REG_B:   extract_load = {{24{lane[7]}}, lane[7:0]};
      REG_H:   extract_load = {{16{lane[15]}}, lane[15:0]};
      REG_BX:  extract_load = {24'h000000, lane[7:0]};
      REG_HX:  extract_load = {16'h0000, lane[15:0]};
      default: extract_load = word;
    endcase
  endfunction

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Illegal or misaligned ops skip the bus entirely and report straight from RESP.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          state_d = acc_ok ? S_REQ : S_RESP;
        end
      end
      S_REQ: begin
        if (mem_gnt) begin
          state_d = is_store_q ? S_RESP : S_WAIT;
        end
      end
      S_WAIT: begin
        if (mem_rvalid) begin
          state_d = S_RESP;
        end
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    in_ready   = 1'b0;
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    mem_addr   = '0;
    mem_be     = 4'b0000;
    mem_wdata  = 32'h0;
    done_valid = 1'b0;
    done_err   = 1'b0;
    done_we    = 1'b0;
    done_rd    = 5'd0;
    done_data  = 32'h0;
    case (state_q)
      S_IDLE: in_ready = 1'b1;
      S_REQ: begin
        mem_req   = 1'b1;
        mem_we    = is_store_q;
        mem_addr  = {addr_q, 2'b00};
        mem_be    = be_q;
        mem_wdata = wdata_q;
      end
      S_RESP: begin
        done_valid = 1'b1;
        done_err   = err_q;
        done_we    = !err_q && !is_store_q && (rd_q != 5'd0);
        done_rd    = rd_q;
        done_data  = (err_q || is_store_q) ? 32'h0 : data_q;
      end
      default: ;
    endcase
  end

  // Request fields are frozen at accept so the bus sees them bit-stable through any grant stall.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      is_store_q <= 1'b0;
      reg_mask_q <= REG_B;
      off_q      <= 2'b00;
      addr_q     <= '0;
      be_q       <= 4'b0000;
      wdata_q    <= 32'h0;
      data_q     <= 32'h0;
      rd_q       <= 5'd0;
      err_q      <= 1'b0;
    end else if (accept) begin
      is_store_q <= (in_mem_op == MEM_STORE);
      reg_mask_q <= in_reg_mask;
      off_q      <= in_addr[1:0];
      addr_q     <= in_addr[ADDR_W-1:2];
      be_q       <= acc_be;
      wdata_q    <= acc_wdata;
      data_q     <= 32'h0;
      rd_q       <= in_rd;
      err_q      <= !acc_ok;
    end else if (state_q == S_WAIT && mem_rvalid) begin
      data_q <= extract_load(mem_rdata, reg_mask_q, off_q);
    end
  end

endmodule

// File: tb/tb_rv32i_lsu.sv
// Scoreboard bench for rv32i_lsu: a byte-level memory model predicts bus requests and
// writeback results; a bus responder and a done monitor check them as they appear.

module tb_rv32i_lsu;
  import rv32i::*;

  localparam int ADDR_W = 32;

  logic              clk = 1'b0;
  logic              reset_n = 1'b0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  mem_op_e           in_mem_op = MEM_LOAD;
  ram_mask_e         in_ram_mask = RAM_B;
  reg_mask_e         in_reg_mask = REG_B;
  logic [ADDR_W-1:0] in_addr = '0;
  logic [31:0]       in_wdata = 32'h0;
  logic [4:0]        in_rd = 5'd0;
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [3:0]        mem_be;
  logic [31:0]       mem_wdata;
  logic              mem_gnt = 1'b0;
  logic              mem_rvalid = 1'b0;
  logic [31:0]       mem_rdata = 32'h0;
  logic              done_valid;
  logic              done_err;
  logic              done_we;
  logic [4:0]        done_rd;
  logic [31:0]       done_data;

  rv32i_lsu #(.ADDR_W(ADDR_W)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_mem_op  (in_mem_op),
    .in_ram_mask(in_ram_mask),
    .in_reg_mask(in_reg_mask),
    .in_addr    (in_addr),
    .in_wdata   (in_wdata),
    .in_rd      (in_rd),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_be     (mem_be),
    .mem_wdata  (mem_wdata),
    .mem_gnt    (mem_gnt),
    .mem_rvalid (mem_rvalid),
    .mem_rdata  (mem_rdata),
    .done_valid (done_valid),
    .done_err   (done_err),
    .done_we    (done_we),
    .done_rd    (done_rd),
    .done_data  (done_data)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic        err;
    logic        we;
    logic [4:0]  rd;
    logic [31:0] data;
  } done_exp_t;

  typedef struct {
    logic [31:0] addr;
    logic        we;
    logic [3:0]  be;
    logic [31:0] wdata;
  } bus_exp_t;

  done_exp_t   done_q[$];
  bus_exp_t    bus_q[$];
  logic [7:0]  mem [logic [31:0]];

  int checks = 0;
  int errors = 0;
  int gnt_dly_force = -1;
  int rv_dly_force = -1;
  int req_count = 0;
  int gnt_count = 0;
  int done_count = 0;
  int last_accept_cyc = 0;
  int last_req_cyc = 0;
  int last_gnt_cyc = 0;
  int last_done_cyc = 0;
  logic [31:0] last_maddr = 32'h0;
  logic [3:0]  last_be = 4'h0;
  logic [31:0] last_mwdata = 32'h0;
  logic [31:0] last_done_data = 32'h0;
  logic        last_done_we = 1'b0;
  logic        last_done_err = 1'b0;

  task automatic check_output(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
    end
  endtask

  task automatic finish_sim();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  endtask

  task automatic timeout(input string what);
    checks++;
    errors++;
    $display("[TB] FAIL timeout_%s: got no response, expected one within the cycle bound", what);
    finish_sim();
  endtask

  function automatic logic [7:0] rd_byte(input logic [31:0] a);
    return mem.exists(a) ? mem[a] : 8'h00;
  endfunction

  function automatic int acc_size(input logic is_store, input logic [2:0] rm,
                                  input logic [1:0] sm);
    if (is_store) return (sm == 2'd0) ? 1 : (sm == 2'd1) ? 2 : (sm == 2'd2) ? 4 : 0;
    case (rm)
      3'd0, 3'd3: return 1;
      3'd1, 3'd4: return 2;
      3'd2:       return 4;
      default:    return 0;
    endcase
  endfunction

  // Predict the outcome from byte-level memory semantics, then present the op for one accept.
  task automatic apply_stimulus(input logic is_store, input logic [2:0] rm, input logic [1:0] sm,
                                input logic [31:0] addr, input logic [31:0] wdata,
                                input logic [4:0] rd);
    done_exp_t d;
    bus_exp_t  b;
    logic [31:0] v;
    int sz;
    int n;
    n = 0;
    @(negedge clk);
    while (!in_ready) begin
      n++;
      if (n > 100) timeout("ready");
      @(negedge clk);
    end
    sz = acc_size(is_store, rm, sm);
    d.err = (sz == 0);
    if (sz != 0 && (addr % sz) != 0) d.err = 1'b1;
    d.rd   = rd;
    d.we   = !is_store && !d.err && (rd != 5'd0);
    d.data = 32'h0;
    if (!d.err) begin
      b.addr  = addr & ~32'h3;
      b.we    = is_store;
      b.be    = 4'h0;
      b.wdata = 32'h0;
      for (int i = 0; i < sz; i++) b.be[(addr + i) % 4] = 1'b1;
      if (is_store) begin
        for (int k = 0; k < 4; k++) b.wdata[8*k +: 8] = wdata[8*(k % sz) +: 8];
        for (int i = 0; i < sz; i++) mem[addr + i] = wdata[8*i +: 8];
      end else begin
        v = 32'h0;
        for (int i = 0; i < sz; i++) v |= 32'(rd_byte(addr + i)) << (8 * i);
        if ((rm == 3'd0 || rm == 3'd1) && v[8*sz-1]) v |= 32'hFFFF_FFFF << (8 * sz);
        d.data = v;
      end
      bus_q.push_back(b);
    end
    done_q.push_back(d);
    in_mem_op       = is_store ? MEM_STORE : MEM_LOAD;
    in_ram_mask     = ram_mask_e'(sm);
    in_reg_mask     = reg_mask_e'(rm);
    in_addr         = addr;
    in_wdata        = wdata;
    in_rd           = rd;
    in_valid        = 1'b1;
    last_accept_cyc = cyc;
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
      if (n > 200) timeout("idle");
    end while (!(in_ready && done_q.size() == 0));
  endtask

  // Writeback monitor: every done pulse must match the oldest outstanding prediction.
  done_exp_t md;
  always @(negedge clk) begin
    if (reset_n && done_valid) begin
      done_count++;
      last_done_cyc  = cyc;
      last_done_data = done_data;
      last_done_we   = done_we;
      last_done_err  = done_err;
      if (done_q.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL unexpected_done: got done_valid=1, expected 0 with nothing pending");
      end else begin
        md = done_q.pop_front();
        check_output("done_err", 32'(done_err), 32'(md.err));
        check_output("done_we", 32'(done_we), 32'(md.we));
        check_output("done_rd", 32'(done_rd), 32'(md.rd));
        check_output("done_data", done_data, md.data);
        check_output("ready_low_in_resp", 32'(in_ready), 32'h0);
      end
    end
  end

  // Bus responder: checks each request, stalls the grant, then returns read data from the model.
  initial begin
    bus_exp_t    bx;
    logic [68:0] snap;
    logic [31:0] a;
    int dly;
    int rdly;
    forever begin
      @(negedge clk);
      mem_gnt    = 1'b0;
      mem_rvalid = 1'b0;
      if (mem_req) begin
        req_count++;
        last_req_cyc = cyc;
        last_maddr   = mem_addr;
        last_be      = mem_be;
        last_mwdata  = mem_wdata;
        if (bus_q.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL unexpected_req: got mem_req=1, expected 0 with no legal op pending");
        end else begin
          bx = bus_q.pop_front();
          check_output("mem_addr", mem_addr, bx.addr);
          check_output("mem_we", 32'(mem_we), 32'(bx.we));
          check_output("mem_be", 32'(mem_be), 32'(bx.be));
          if (bx.we) check_output("mem_wdata", mem_wdata, bx.wdata);
        end
        snap = {mem_addr, mem_we, mem_be, mem_wdata};
        dly  = (gnt_dly_force >= 0) ? gnt_dly_force : int'($urandom_range(0, 3));
        repeat (dly) begin
          @(negedge clk);
          check_output("gnt_stall_hold",
                       32'(mem_req && ({mem_addr, mem_we, mem_be, mem_wdata} == snap)), 32'h1);
        end
        a            = mem_addr;
        mem_gnt      = 1'b1;
        gnt_count++;
        last_gnt_cyc = cyc;
        if (!snap[36]) begin
          @(negedge clk);
          mem_gnt = 1'b0;
          rdly = (rv_dly_force >= 0) ? rv_dly_force : int'($urandom_range(0, 2));
          repeat (rdly) @(negedge clk);
          mem_rdata  = {rd_byte(a + 3), rd_byte(a + 2), rd_byte(a + 1), rd_byte(a)};
          mem_rvalid = 1'b1;
        end
      end
    end
  end

  initial begin
    int rc0;
    int dc0;
    int g0;
    int n;
    logic        is_store;
    logic [2:0]  rm;
    logic [1:0]  sm;

    repeat (3) @(negedge clk);
    check_output("reset_in_ready", 32'(in_ready), 32'h1);
    check_output("reset_mem_req", 32'(mem_req), 32'h0);
    check_output("reset_done_valid", 32'(done_valid), 32'h0);
    check_output("reset_mem_be", 32'(mem_be), 32'h0);
    check_output("reset_done_data", done_data, 32'h0);
    reset_n = 1'b1;

    {mem[32'h1003], mem[32'h1002], mem[32'h1001], mem[32'h1000]} = 32'h80FF_FF7F;
    {mem[32'h2003], mem[32'h2002], mem[32'h2001], mem[32'h2000]} = 32'hBEEF_1234;
    {mem[32'h2007], mem[32'h2006], mem[32'h2005], mem[32'h2004]} = 32'hCAFE_F00D;

    apply_stimulus(1'b0, REG_B, RAM_B, 32'h1003, 32'h0, 5'd5);
    wait_idle();
    check_output("lb_be", 32'(last_be), 32'h8);
    check_output("lb_addr", last_maddr, 32'h1000);
    check_output("lb_data", last_done_data, 32'hFFFF_FF80);
    check_output("lb_we", 32'(last_done_we), 32'h1);

    apply_stimulus(1'b0, REG_HX, RAM_B, 32'h2002, 32'h0, 5'd6);
    wait_idle();
    check_output("lhu_be", 32'(last_be), 32'hC);
    check_output("lhu_data", last_done_data, 32'h0000_BEEF);

    apply_stimulus(1'b0, REG_W, RAM_B, 32'h2004, 32'h0, 5'd7);
    wait_idle();
    check_output("lw_be", 32'(last_be), 32'hF);
    check_output("lw_data", last_done_data, 32'hCAFE_F00D);

    gnt_dly_force = 3;
    apply_stimulus(1'b1, REG_B, RAM_B, 32'h3001, 32'h1234_56AB, 5'd8);
    wait_idle();
    gnt_dly_force = -1;
    check_output("sb_be", 32'(last_be), 32'h2);
    check_output("sb_wdata", last_mwdata, 32'hABAB_ABAB);
    check_output("sb_gnt_stall", 32'(last_gnt_cyc - last_req_cyc), 32'd3);
    check_output("sb_done_latency", 32'(last_done_cyc - last_gnt_cyc), 32'd1);
    check_output("sb_done_we", 32'(last_done_we), 32'h0);

    rc0 = req_count;
    apply_stimulus(1'b0, REG_W, RAM_B, 32'h4002, 32'h0, 5'd9);
    wait_idle();
    check_output("lw_mis_latency", 32'(last_done_cyc - last_accept_cyc), 32'd1);
    check_output("lw_mis_err", 32'(last_done_err), 32'h1);
    apply_stimulus(1'b1, REG_B, RAM_H, 32'h4001, 32'h5555_AAAA, 5'd10);
    wait_idle();
    check_output("sh_mis_latency", 32'(last_done_cyc - last_accept_cyc), 32'd1);
    check_output("mis_no_req", 32'(req_count - rc0), 32'd0);
    check_output("mis_ready_back", 32'(in_ready), 32'h1);

    rc0 = req_count;
    apply_stimulus(1'b0, REG_W, RAM_B, 32'h1000, 32'h0, 5'd0);
    wait_idle();
    check_output("rd0_bus_access", 32'(req_count - rc0), 32'd1);
    check_output("rd0_we", 32'(last_done_we), 32'h0);
    apply_stimulus(1'b0, 3'd6, RAM_B, 32'h1000, 32'h0, 5'd4);
    wait_idle();
    check_output("illegal_mask_err", 32'(last_done_err), 32'h1);

    gnt_dly_force = 0;
    rv_dly_force  = 0;
    apply_stimulus(1'b1, REG_B, RAM_W, 32'h1010, 32'hDEAD_BEEF, 5'd1);
    wait_idle();
    check_output("store_min_latency", 32'(last_done_cyc - last_accept_cyc), 32'd2);
    apply_stimulus(1'b0, REG_W, RAM_B, 32'h1010, 32'h0, 5'd2);
    wait_idle();
    check_output("load_min_latency", 32'(last_done_cyc - last_accept_cyc), 32'd3);

    // Reset while the load waits for read data; the late rvalid must be ignored.
    gnt_dly_force = 0;
    rv_dly_force  = 6;
    g0 = gnt_count;
    apply_stimulus(1'b0, REG_W, RAM_B, 32'h1000, 32'h0, 5'd3);
    n = 0;
    while (gnt_count == g0) begin
      @(negedge clk);
      n++;
      if (n > 50) timeout("gnt");
    end
    @(negedge clk);
    dc0 = done_count;
    #1 reset_n = 1'b0;
    done_q.delete();
    #1;
    check_output("rst_mem_req", 32'(mem_req), 32'h0);
    check_output("rst_done_valid", 32'(done_valid), 32'h0);
    check_output("rst_in_ready", 32'(in_ready), 32'h1);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    repeat (12) @(negedge clk);
    check_output("stray_rvalid_no_done", 32'(done_count - dc0), 32'd0);
    gnt_dly_force = -1;
    rv_dly_force  = -1;
    apply_stimulus(1'b0, REG_W, RAM_B, 32'h2004, 32'h0, 5'd11);
    wait_idle();
    check_output("post_reset_lw", last_done_data, 32'hCAFE_F00D);

    for (int a = 32'h1000; a < 32'h1040; a++) mem[a] = 8'($urandom);
    for (int k = 0; k < 200; k++) begin
      is_store = 1'($urandom_range(0, 1));
      rm = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(5, 7)) : 3'($urandom_range(0, 4));
      sm = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
      apply_stimulus(is_store, rm, sm, 32'h1000 + $urandom_range(0, 63), $urandom,
                     5'($urandom));
    end
    wait_idle();
    check_output("bus_q_drained", 32'(bus_q.size()), 32'd0);
    finish_sim();
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got no end of test, expected completion within time limit");
    errors++;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
